// File: rtl/pool_pkg.sv
// Purpose: shared types and respot constants for the billiards turn logic and ball movement blocks.
// Latency: n/a, declarations only.
// Backpressure: n/a.
package pool_pkg;

    // Turn phases of one shot.
    typedef enum logic [2:0] {
        ST_AIM       = 3'd0,
        ST_MOVING    = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_EVAL      = 3'd3,
        ST_RESPOT    = 3'd4,
        ST_GAME_OVER = 3'd5
    } state_t;

    // Screen location of a ball's top-left corner, in pixels.
    typedef logic signed [10:0] loc_t;

    // Respot locations, also used by the ball movement blocks at power-up.
    localparam loc_t POOL_RED_START_X   = 11'sd280;
    localparam loc_t POOL_RED_START_Y   = 11'sd185;
    localparam loc_t POOL_WHITE_START_X = 11'sd120;
    localparam loc_t POOL_WHITE_START_Y = 11'sd185;

endpackage

// File: rtl/frame_settle_counter.sv
// Purpose: counts frames since the cue strike and consecutive frames with both balls stopped.
// Latency: outputs are combinational on the current startOfFrame and registered counts.
// Backpressure: none; counts only on frame pulses while a shot is active.
//
// Ports: start_i clears both counters (entry to MOVING); active_i/in_settle_i tell the
// counter which shot phase the FSM is in; sof_i is the frame pulse; both_stopped_i is
// the AND of the ball stopped flags. min_reached_o, settled_o and timeout_o go to the FSM.
module frame_settle_counter
    import pool_pkg::*;
#(
    parameter int MIN_SHOT_FRAMES = 4,
    parameter int SETTLE_FRAMES   = 3,
    parameter int MAX_SHOT_FRAMES = 600
) (
    input  logic clk,
    input  logic resetN,
    input  logic start_i,
    input  logic active_i,
    input  logic in_settle_i,
    input  logic sof_i,
    input  logic both_stopped_i,
    output logic min_reached_o,
    output logic settled_o,
    output logic timeout_o
);

    localparam int FW = $clog2(MAX_SHOT_FRAMES + 1);
    localparam int SW = $clog2(SETTLE_FRAMES + 1);
    localparam logic [FW-1:0] FRAME_MIN   = FW'(MIN_SHOT_FRAMES);
    localparam logic [FW-1:0] FRAME_LAST  = FW'(MAX_SHOT_FRAMES - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_FRAMES - 1);

    logic [FW-1:0] frame_q, frame_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          tick;

    assign tick = sof_i && active_i;

    // Stop checks start once MIN_SHOT_FRAMES frames have already elapsed.
    assign min_reached_o = (frame_q >= FRAME_MIN);
    // Fires on the frame that brings the count to MAX_SHOT_FRAMES.
    assign timeout_o     = tick && (frame_q == FRAME_LAST);
    // Fires on the frame that would make the stopped run SETTLE_FRAMES long.
    assign settled_o     = tick && in_settle_i && both_stopped_i && (settle_q == SETTLE_LAST);

    always_comb begin
        frame_d  = frame_q;
        settle_d = settle_q;
        if (start_i) begin
            frame_d  = '0;
            settle_d = '0;
        end else if (tick) begin
            frame_d = frame_q + 1'b1;
            if (!both_stopped_i) begin
                settle_d = '0;
            end else if (in_settle_i) begin
                settle_d = settle_q + 1'b1;
            end else if (min_reached_o) begin
                // First stopped frame counts as the first settle frame.
                settle_d = SW'(1);
            end else begin
                settle_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_q  <= '0;
            settle_q <= '0;
        end else begin
            frame_q  <= frame_d;
            settle_q <= settle_d;
        end
    end

endmodule

// File: rtl/pool_turn_sequencer.sv
// Purpose: turn-level FSM for billiards: aim, balls moving, settle, evaluate, respot, game over.
// Latency: outcome registered in the single EVAL clk; turn_over pulses on the following clk.
// Backpressure: none; shot/restart requests outside AIM/GAME_OVER are dropped.
//
// Ports: frame pulse, shot/restart requests, ball stopped flags, pocket collisions and
// current ball locations in; turn_over pulse with the locations to load, shot_enable,
// current_player, scores, foul and game_over out.
module pool_turn_sequencer
    import pool_pkg::*;
#(
    parameter loc_t RED_START_X     = POOL_RED_START_X,
    parameter loc_t RED_START_Y     = POOL_RED_START_Y,
    parameter loc_t WHITE_START_X   = POOL_WHITE_START_X,
    parameter loc_t WHITE_START_Y   = POOL_WHITE_START_Y,
    parameter int   MIN_SHOT_FRAMES = 4,
    parameter int   SETTLE_FRAMES   = 3,
    parameter int   MAX_SHOT_FRAMES = 600,
    parameter int   WIN_SCORE       = 5
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               shot_request,
    input  logic               restart_request,
    input  logic               red_ball_stopped,
    input  logic               white_ball_stopped,
    input  logic               collision_Red_Black,
    input  logic               collision_White_Black,
    input  logic signed [10:0] red_x_loc,
    input  logic signed [10:0] red_y_loc,
    input  logic signed [10:0] white_x_loc,
    input  logic signed [10:0] white_y_loc,
    output logic               turn_over,
    output logic signed [10:0] new_red_x_loc,
    output logic signed [10:0] new_red_y_loc,
    output logic signed [10:0] new_white_x_loc,
    output logic signed [10:0] new_white_y_loc,
    output logic               shot_enable,
    output logic               current_player,
    output logic [3:0]         score_p1,
    output logic [3:0]         score_p2,
    output logic               foul,
    output logic               game_over
);

    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    state_t     state_q, state_d;
    logic       player_q, player_d;
    logic [3:0] score_p1_q, score_p1_d, score_p2_q, score_p2_d;
    logic       foul_q, foul_d;
    logic       red_pot_q, red_pot_d, white_pot_q, white_pot_d;
    loc_t       new_rx_q, new_rx_d, new_ry_q, new_ry_d;
    loc_t       new_wx_q, new_wx_d, new_wy_q, new_wy_d;

    logic both_stopped, shot_start, in_shot, in_settle;
    logic min_reached, settled, timeout;

    assign both_stopped = red_ball_stopped && white_ball_stopped;
    assign shot_start   = (state_q == ST_AIM) && shot_request;
    assign in_settle    = (state_q == ST_SETTLE);
    assign in_shot      = (state_q == ST_MOVING) || in_settle;

    frame_settle_counter #(
        .MIN_SHOT_FRAMES (MIN_SHOT_FRAMES),
        .SETTLE_FRAMES   (SETTLE_FRAMES),
        .MAX_SHOT_FRAMES (MAX_SHOT_FRAMES)
    ) u_cnt (
        .clk            (clk),
        .resetN         (resetN),
        .start_i        (shot_start),
        .active_i       (in_shot),
        .in_settle_i    (in_settle),
        .sof_i          (startOfFrame),
        .both_stopped_i (both_stopped),
        .min_reached_o  (min_reached),
        .settled_o      (settled),
        .timeout_o      (timeout)
    );

    always_comb begin
        state_d     = state_q;
        player_d    = player_q;
        score_p1_d  = score_p1_q;
        score_p2_d  = score_p2_q;
        foul_d      = foul_q;
        red_pot_d   = red_pot_q;
        white_pot_d = white_pot_q;
        new_rx_d    = new_rx_q;
        new_ry_d    = new_ry_q;
        new_wx_d    = new_wx_q;
        new_wy_d    = new_wy_q;

        // Pockets are watched on every clk of the shot, including the one leaving for EVAL.
        if (in_shot) begin
            red_pot_d   = red_pot_q   | collision_Red_Black;
            white_pot_d = white_pot_q | collision_White_Black;
        end

        unique case (state_q)
            ST_AIM: begin
                if (shot_request) begin
                    state_d     = ST_MOVING;
                    red_pot_d   = 1'b0;
                    white_pot_d = 1'b0;
                end
            end
            ST_MOVING: begin
                if (timeout) begin
                    state_d = ST_EVAL;
                end else if (startOfFrame && min_reached && both_stopped) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (timeout || settled) begin
                    state_d = ST_EVAL;
                end else if (startOfFrame && !both_stopped) begin
                    state_d = ST_MOVING;
                end
            end
            ST_EVAL: begin
                state_d = ST_RESPOT;
                if (white_pot_q) begin
                    foul_d   = 1'b1;
                    new_wx_d = WHITE_START_X;
                    new_wy_d = WHITE_START_Y;
                    new_rx_d = red_pot_q ? RED_START_X : red_x_loc;
                    new_ry_d = red_pot_q ? RED_START_Y : red_y_loc;
                    player_d = ~player_q;
                end else if (red_pot_q) begin
                    foul_d   = 1'b0;
                    new_rx_d = RED_START_X;
                    new_ry_d = RED_START_Y;
                    new_wx_d = white_x_loc;
                    new_wy_d = white_y_loc;
                    if (!player_q) begin
                        if (score_p1_q != WIN) score_p1_d = score_p1_q + 1'b1;
                    end else begin
                        if (score_p2_q != WIN) score_p2_d = score_p2_q + 1'b1;
                    end
                end else begin
                    foul_d   = 1'b0;
                    new_rx_d = red_x_loc;
                    new_ry_d = red_y_loc;
                    new_wx_d = white_x_loc;
                    new_wy_d = white_y_loc;
                    player_d = ~player_q;
                end
            end
            ST_RESPOT: begin
                state_d = ((score_p1_q == WIN) || (score_p2_q == WIN)) ? ST_GAME_OVER : ST_AIM;
            end
            ST_GAME_OVER: begin
                if (restart_request) begin
                    // Reuse RESPOT so the ball blocks get one turn_over with the start locations.
                    state_d    = ST_RESPOT;
                    score_p1_d = '0;
                    score_p2_d = '0;
                    foul_d     = 1'b0;
                    player_d   = 1'b0;
                    new_rx_d   = RED_START_X;
                    new_ry_d   = RED_START_Y;
                    new_wx_d   = WHITE_START_X;
                    new_wy_d   = WHITE_START_Y;
                end
            end
            default: state_d = ST_AIM;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_AIM;
            player_q    <= 1'b0;
            score_p1_q  <= '0;
            score_p2_q  <= '0;
            foul_q      <= 1'b0;
            red_pot_q   <= 1'b0;
            white_pot_q <= 1'b0;
            new_rx_q    <= RED_START_X;
            new_ry_q    <= RED_START_Y;
            new_wx_q    <= WHITE_START_X;
            new_wy_q    <= WHITE_START_Y;
        end else begin
            state_q     <= state_d;
            player_q    <= player_d;
            score_p1_q  <= score_p1_d;
            score_p2_q  <= score_p2_d;
            foul_q      <= foul_d;
            red_pot_q   <= red_pot_d;
            white_pot_q <= white_pot_d;
            new_rx_q    <= new_rx_d;
            new_ry_q    <= new_ry_d;
            new_wx_q    <= new_wx_d;
            new_wy_q    <= new_wy_d;
        end
    end

    assign turn_over       = (state_q == ST_RESPOT);
    assign shot_enable     = (state_q == ST_AIM);
    assign game_over       = (state_q == ST_GAME_OVER);
    assign current_player  = player_q;
    assign score_p1        = score_p1_q;
    assign score_p2        = score_p2_q;
    assign foul            = foul_q;
    assign new_red_x_loc   = new_rx_q;
    assign new_red_y_loc   = new_ry_q;
    assign new_white_x_loc = new_wx_q;
    assign new_white_y_loc = new_wy_q;

endmodule

// File: tb/tb_pool_turn_sequencer.sv
// Purpose: randomized self-checking bench for pool_turn_sequencer against a shot-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pool_turn_sequencer;

    localparam int MAXF = 600;
    localparam int MINF = 4;
    localparam int SETF = 3;
    localparam int WIN  = 5;
    localparam int RSX = 280, RSY = 185, WSX = 120, WSY = 185;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic startOfFrame = 1'b0, shot_request = 1'b0, restart_request = 1'b0;
    logic red_ball_stopped = 1'b1, white_ball_stopped = 1'b1;
    logic collision_Red_Black = 1'b0, collision_White_Black = 1'b0;
    logic signed [10:0] red_x_loc = '0, red_y_loc = '0, white_x_loc = '0, white_y_loc = '0;
    logic turn_over, shot_enable, current_player, foul, game_over;
    logic signed [10:0] new_red_x_loc, new_red_y_loc, new_white_x_loc, new_white_y_loc;
    logic [3:0] score_p1, score_p2;

    always #5 clk = ~clk;

    pool_turn_sequencer dut (
        .clk                   (clk),
        .resetN                (resetN),
        .startOfFrame          (startOfFrame),
        .shot_request          (shot_request),
        .restart_request       (restart_request),
        .red_ball_stopped      (red_ball_stopped),
        .white_ball_stopped    (white_ball_stopped),
        .collision_Red_Black   (collision_Red_Black),
        .collision_White_Black (collision_White_Black),
        .red_x_loc             (red_x_loc),
        .red_y_loc             (red_y_loc),
        .white_x_loc           (white_x_loc),
        .white_y_loc           (white_y_loc),
        .turn_over             (turn_over),
        .new_red_x_loc         (new_red_x_loc),
        .new_red_y_loc         (new_red_y_loc),
        .new_white_x_loc       (new_white_x_loc),
        .new_white_y_loc       (new_white_y_loc),
        .shot_enable           (shot_enable),
        .current_player        (current_player),
        .score_p1              (score_p1),
        .score_p2              (score_p2),
        .foul                  (foul),
        .game_over             (game_over)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Capture everything presented with each turn_over pulse.
    int to_cnt = 0, to_frame = 0, cur_frame = 0;
    logic signed [10:0] cap_rx, cap_ry, cap_wx, cap_wy;
    logic [3:0] cap_s1, cap_s2;
    logic cap_foul, cap_p;

    always @(posedge clk) begin
        #1;
        if (turn_over) begin
            to_cnt++;
            to_frame = cur_frame;
            cap_rx = new_red_x_loc;   cap_ry = new_red_y_loc;
            cap_wx = new_white_x_loc; cap_wy = new_white_y_loc;
            cap_s1 = score_p1; cap_s2 = score_p2;
            cap_foul = foul; cap_p = current_player;
        end
    end

    // Reference model state.
    int exp_p = 0, exp_foul = 0;
    int exp_s[2] = '{0, 0};
    int exp_nrx = RSX, exp_nry = RSY, exp_nwx = WSX, exp_nwy = WSY;
    bit exp_gover = 1'b0;
    int cur_rx, cur_ry, cur_wx, cur_wy;

    // Per-frame stopped flags of the next shot, and its pocket events (frame 0 = none).
    bit prof_r [1:MAXF];
    bit prof_w [1:MAXF];
    int pr_f = 0, pr_off = 0, pw_f = 0, pw_off = 0;

    // early_k frames stopped right after the strike, moving until stop_f (0 = never),
    // then stopped; glitch_f makes one ball move on that single frame.
    task automatic build(input int early_k, input int stop_f, input int glitch_f);
        for (int f = 1; f <= MAXF; f++) begin
            if (f <= early_k) begin
                prof_r[f] = 1'b1; prof_w[f] = 1'b1;
            end else if (stop_f == 0 || f < stop_f) begin
                prof_r[f] = 1'($urandom_range(0, 1));
                prof_w[f] = prof_r[f] ? 1'b0 : 1'($urandom_range(0, 1));
            end else begin
                prof_r[f] = 1'b1; prof_w[f] = 1'b1;
            end
        end
        if (glitch_f != 0) begin
            if ($urandom_range(0, 1) == 1) prof_r[glitch_f] = 1'b0;
            else                           prof_w[glitch_f] = 1'b0;
        end
    endtask

    // The shot ends on the first frame closing a run of SETF stopped frames that starts
    // after MINF elapsed frames, or on frame MAXF, whichever comes first.
    function automatic int calc_ef();
        int ef;
        bit found;
        ef = MAXF;
        found = 1'b0;
        for (int f = MINF + SETF; f <= MAXF; f++) begin
            bit ok;
            ok = 1'b1;
            for (int k = 0; k < SETF; k++)
                if (!(prof_r[f - k] && prof_w[f - k])) ok = 1'b0;
            if (ok && !found) begin
                ef = f;
                found = 1'b1;
            end
        end
        return ef;
    endfunction

    task automatic model_eval(input bit pr, input bit pw);
        if (pw) begin
            exp_foul = 1; exp_nwx = WSX; exp_nwy = WSY;
            exp_nrx = pr ? RSX : cur_rx;
            exp_nry = pr ? RSY : cur_ry;
            exp_p = 1 - exp_p;
        end else if (pr) begin
            exp_foul = 0;
            if (exp_s[exp_p] < WIN) exp_s[exp_p] = exp_s[exp_p] + 1;
            exp_nrx = RSX; exp_nry = RSY; exp_nwx = cur_wx; exp_nwy = cur_wy;
        end else begin
            exp_foul = 0;
            exp_nrx = cur_rx; exp_nry = cur_ry; exp_nwx = cur_wx; exp_nwy = cur_wy;
            exp_p = 1 - exp_p;
        end
        exp_gover = (exp_s[0] == WIN) || (exp_s[1] == WIN);
    endtask

    task automatic check_turn(input string t);
        check_eq({t, "_new_red_x"}, 32'(cap_rx), exp_nrx);
        check_eq({t, "_new_red_y"}, 32'(cap_ry), exp_nry);
        check_eq({t, "_new_white_x"}, 32'(cap_wx), exp_nwx);
        check_eq({t, "_new_white_y"}, 32'(cap_wy), exp_nwy);
        check_eq({t, "_score_p1"}, 32'(cap_s1), exp_s[0]);
        check_eq({t, "_score_p2"}, 32'(cap_s2), exp_s[1]);
        check_eq({t, "_foul"}, 32'(cap_foul), exp_foul);
        check_eq({t, "_player"}, 32'(cap_p), exp_p);
    endtask

    task automatic run_shot(input string t, input int ef, input bit sof_at_shot, input int noise_f);
        int base;
        cur_rx = $urandom_range(20, 600); cur_ry = $urandom_range(20, 400);
        cur_wx = $urandom_range(20, 600); cur_wy = $urandom_range(20, 400);
        red_x_loc = 11'(cur_rx);   red_y_loc = 11'(cur_ry);
        white_x_loc = 11'(cur_wx); white_y_loc = 11'(cur_wy);
        red_ball_stopped = 1'b1; white_ball_stopped = 1'b1;
        base = to_cnt;
        @(negedge clk);
        shot_request = 1'b1; startOfFrame = sof_at_shot;
        @(negedge clk);
        shot_request = 1'b0; startOfFrame = 1'b0;
        check_eq({t, "_shot_enable_moving"}, 32'(shot_enable), 0);
        for (int f = 1; f <= ef; f++) begin
            cur_frame = f;
            red_ball_stopped = prof_r[f]; white_ball_stopped = prof_w[f];
            startOfFrame = 1'b1;
            shot_request = (f == noise_f);
            collision_Red_Black   = (f == pr_f) && (pr_off == 0);
            collision_White_Black = (f == pw_f) && (pw_off == 0);
            @(negedge clk);
            startOfFrame = 1'b0; shot_request = 1'b0;
            for (int c = 1; c <= 3; c++) begin
                collision_Red_Black   = (f == pr_f) && (pr_off == c);
                collision_White_Black = (f == pw_f) && (pw_off == c);
                @(negedge clk);
            end
            collision_Red_Black = 1'b0; collision_White_Black = 1'b0;
        end
        check_eq({t, "_turn_over_count"}, to_cnt - base, 1);
        check_eq({t, "_turn_over_frame"}, to_frame, ef);
        model_eval(pr_f != 0, pw_f != 0);
        check_turn(t);
        check_eq({t, "_turn_over_low"}, 32'(turn_over), 0);
        check_eq({t, "_shot_enable_after"}, 32'(shot_enable), 32'(!exp_gover));
        check_eq({t, "_game_over_after"}, 32'(game_over), 32'(exp_gover));
    endtask

    task automatic game_over_check(input string t);
        int base;
        check_eq({t, "_game_over"}, 32'(game_over), 1);
        check_eq({t, "_shot_enable"}, 32'(shot_enable), 0);
        base = to_cnt;
        @(negedge clk);
        shot_request = 1'b1; startOfFrame = 1'b1;
        @(negedge clk);
        shot_request = 1'b0; startOfFrame = 1'b0;
        repeat (6) @(negedge clk);
        check_eq({t, "_shot_ignored"}, to_cnt - base, 0);
        check_eq({t, "_still_over"}, 32'(game_over), 1);
        restart_request = 1'b1;
        @(negedge clk);
        restart_request = 1'b0;
        repeat (3) @(negedge clk);
        check_eq({t, "_restart_turn_over"}, to_cnt - base, 1);
        exp_s[0] = 0; exp_s[1] = 0; exp_p = 0; exp_foul = 0; exp_gover = 1'b0;
        exp_nrx = RSX; exp_nry = RSY; exp_nwx = WSX; exp_nwy = WSY;
        check_turn({t, "_restart"});
        check_eq({t, "_restart_aim"}, 32'(shot_enable), 1);
        check_eq({t, "_restart_not_over"}, 32'(game_over), 0);
    endtask

    initial begin
        int ef, stop_f, guard;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        check_eq("rst_shot_enable", 32'(shot_enable), 1);
        check_eq("rst_turn_over", 32'(turn_over), 0);
        check_eq("rst_game_over", 32'(game_over), 0);
        check_eq("rst_player", 32'(current_player), 0);
        check_eq("rst_score_p1", 32'(score_p1), 0);
        check_eq("rst_score_p2", 32'(score_p2), 0);
        check_eq("rst_foul", 32'(foul), 0);
        check_eq("rst_new_red_x", 32'(new_red_x_loc), RSX);
        check_eq("rst_new_red_y", 32'(new_red_y_loc), RSY);
        check_eq("rst_new_white_x", 32'(new_white_x_loc), WSX);
        check_eq("rst_new_white_y", 32'(new_white_y_loc), WSY);

        // Plain shot, balls stop at frame 10.
        build(0, 10, 0); pr_f = 0; pw_f = 0;
        ef = calc_ef();
        check_eq("t1_eval_frame_model", ef, 12);
        run_shot("t1", ef, 1'b0, 0);

        // Red potted at frame 5.
        build(0, 8, 0); pr_f = 5; pr_off = 0; pw_f = 0;
        run_shot("t2", calc_ef(), 1'b1, 3);

        // Both potted; white on the very frame that ends the shot.
        build(2, 9, 0); ef = calc_ef();
        pr_f = 6; pr_off = 2; pw_f = ef; pw_off = 0;
        run_shot("t3", ef, 1'b0, 0);

        // Stopped two frames, moving on the third, then settles.
        build(0, 10, 12); pr_f = 0; pw_f = 0;
        run_shot("t4", calc_ef(), 1'b0, 0);

        // Never stops: timeout.
        build(0, 0, 0); pr_f = 0; pw_f = 0;
        run_shot("t5", calc_ef(), 1'b0, 0);

        // Consecutive red pots until the shooter wins.
        guard = 0;
        while (!exp_gover && guard < 12) begin
            build(0, 6, 0); ef = calc_ef();
            pr_f = ef; pr_off = 0; pw_f = 0;
            run_shot("t6", ef, 1'b0, 0);
            guard++;
        end
        game_over_check("t6_go");

        // Random shots.
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                restart_request = 1'b1;
                @(negedge clk);
                restart_request = 1'b0;
                @(negedge clk);
                check_eq("rnd_restart_ignored", 32'(shot_enable), 1);
            end
            stop_f = $urandom_range(5, 14);
            build($urandom_range(0, 3), stop_f,
                  ($urandom_range(0, 2) == 0) ? stop_f + $urandom_range(1, 2) : 0);
            ef = calc_ef();
            pr_f = ($urandom_range(0, 1) == 1) ? $urandom_range(1, ef) : 0;
            pr_off = (pr_f == ef) ? 0 : $urandom_range(0, 3);
            pw_f = ($urandom_range(0, 4) == 0) ? $urandom_range(1, ef) : 0;
            pw_off = (pw_f == ef) ? 0 : $urandom_range(0, 3);
            run_shot("rnd", ef, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 2) == 0) ? $urandom_range(1, ef) : 0);
            if (exp_gover) game_over_check("rnd_go");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
